// File: rtl/rr_arb_2x1.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_2x1
// Purpose  : Two-channel packet-aware round-robin merge into a registered output.
// Revision : 1.0
// ============================================================================
module rr_arb_2x1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             d0_valid,
  input  logic             d1_valid,
  input  logic             d0_last,
  input  logic             d1_last,
  output logic             d0_ready,
  output logic             d1_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             y_last,
  input  logic             y_ready,
  output logic             s
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             y_last_q, y_last_d;
  logic             s_q, s_d;

  logic load_ok;
  logic grant0, grant1;
  logic ready0, ready1;
  logic xfer0, xfer1;

  always_comb begin
    load_ok = !y_valid_q || y_ready;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      IDLE: begin
        grant0 = d0_valid && (!d1_valid || ptr_q);
        grant1 = d1_valid && (!d0_valid || !ptr_q);
      end
      LOCK0:   grant0 = 1'b1;
      LOCK1:   grant1 = 1'b1;
      default: begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
    // Gated by rst_n so neither channel sees an acceptance while reset is held.
    ready0 = rst_n && load_ok && grant0;
    ready1 = rst_n && load_ok && grant1;
    xfer0  = ready0 && d0_valid;
    xfer1  = ready1 && d1_valid;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    s_d       = s_q;
    if (xfer0) begin
      y_d       = d0;
      y_last_d  = d0_last;
      s_d       = 1'b0;
      y_valid_d = 1'b1;
      if (d0_last) begin
        state_d = IDLE;
        ptr_d   = 1'b0;
      end else begin
        state_d = LOCK0;
      end
    end else if (xfer1) begin
      y_d       = d1;
      y_last_d  = d1_last;
      s_d       = 1'b1;
      y_valid_d = 1'b1;
      if (d1_last) begin
        state_d = IDLE;
        ptr_d   = 1'b1;
      end else begin
        state_d = LOCK1;
      end
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b1;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
      s_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
      s_q       <= s_d;
    end
  end

  assign d0_ready = ready0;
  assign d1_ready = ready1;
  assign y        = y_q;
  assign y_valid  = y_valid_q;
  assign y_last   = y_last_q;
  assign s        = s_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_2x1.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_2x1
// Purpose  : Directed vector bench for the two-channel round-robin merge.
// Revision : 1.0
// ============================================================================
module tb_rr_arb_2x1;

  logic       clk;
  logic       rst_n;
  logic [7:0] d0, d1, y;
  logic       d0_valid, d1_valid, d0_last, d1_last;
  logic       d0_ready, d1_ready, y_valid, y_last, y_ready, s;

  int errors = 0;
  int checks = 0;

  rr_arb_2x1 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d0       (d0),
    .d1       (d1),
    .d0_valid (d0_valid),
    .d1_valid (d1_valid),
    .d0_last  (d0_last),
    .d1_last  (d1_last),
    .d0_ready (d0_ready),
    .d1_ready (d1_ready),
    .y        (y),
    .y_valid  (y_valid),
    .y_last   (y_last),
    .y_ready  (y_ready),
    .s        (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       d0v;
    logic [7:0] d0d;
    logic       d0l;
    logic       d1v;
    logic [7:0] d1d;
    logic       d1l;
    logic       yr;
    logic       r0;
    logic       r1;
    logic       yv;
    logic [7:0] yd;
    logic       yl;
    logic       ys;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic d0v, logic [7:0] d0d, logic d0l,
                              logic d1v, logic [7:0] d1d, logic d1l, logic yr,
                              logic r0, logic r1,
                              logic yv, logic [7:0] yd, logic yl, logic ys);
    vec_t v;
    v.d0v = d0v; v.d0d = d0d; v.d0l = d0l;
    v.d1v = d1v; v.d1d = d1d; v.d1l = d1l; v.yr = yr;
    v.r0 = r0; v.r1 = r1; v.yv = yv; v.yd = yd; v.yl = yl; v.ys = ys;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    d0_valid = v.d0v; d0 = v.d0d; d0_last = v.d0l;
    d1_valid = v.d1v; d1 = v.d1d; d1_last = v.d1l;
    y_ready  = v.yr;
  endtask

  // Called at posedge+1: ready is sampled mid-cycle, registered outputs after the edge.
  task automatic apply(vec_t v, int idx);
    drive(v);
    #4;
    check("ready", idx, {30'd0, d0_ready, d1_ready}, {30'd0, v.r0, v.r1});
    @(posedge clk);
    #1;
    check("y_valid", idx, {31'd0, y_valid}, {31'd0, v.yv});
    if (v.yv) begin
      check("y", idx, {24'd0, y}, {24'd0, v.yd});
      check("y_last", idx, {31'd0, y_last}, {31'd0, v.yl});
      check("s", idx, {31'd0, s}, {31'd0, v.ys});
    end
  endtask

  initial begin
    // Tie after reset: strict alternation A0, B0, A0
    vecs.push_back(mk(1,8'hA0,1, 1,8'hB0,1, 1,  1,0, 1,8'hA0,1,0));
    vecs.push_back(mk(1,8'hA0,1, 1,8'hB0,1, 1,  0,1, 1,8'hB0,1,1));
    vecs.push_back(mk(1,8'hA0,1, 1,8'hB0,1, 1,  1,0, 1,8'hA0,1,0));
    // d1 alone, moves pointer to 1
    vecs.push_back(mk(0,8'h00,0, 1,8'h55,1, 1,  0,1, 1,8'h55,1,1));
    // Packet lock: 01,02,03 from d0 while d1 holds 55
    vecs.push_back(mk(1,8'h01,0, 1,8'h55,1, 1,  1,0, 1,8'h01,0,0));
    vecs.push_back(mk(1,8'h02,0, 1,8'h55,1, 1,  1,0, 1,8'h02,0,0));
    vecs.push_back(mk(1,8'h03,1, 1,8'h55,1, 1,  1,0, 1,8'h03,1,0));
    vecs.push_back(mk(0,8'h00,0, 1,8'h55,1, 1,  0,1, 1,8'h55,1,1));
    // Lock with 4-cycle gap on d0; junk on idle d0 lanes must be ignored
    vecs.push_back(mk(1,8'h11,0, 1,8'h66,1, 1,  1,0, 1,8'h11,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,8'hFF,1, 1,8'h66,1, 1,  1,0, 0,8'h11,0,0));
    vecs.push_back(mk(1,8'h12,1, 1,8'h66,1, 1,  1,0, 1,8'h12,1,0));
    vecs.push_back(mk(0,8'h00,0, 1,8'h66,1, 1,  0,1, 1,8'h66,1,1));
    // Backpressure for 5 cycles, then two words back to back
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1,8'h77,1, 1,8'h88,1, 0,  0,0, 1,8'h66,1,1));
    vecs.push_back(mk(1,8'h77,1, 1,8'h88,1, 1,  1,0, 1,8'h77,1,0));
    vecs.push_back(mk(1,8'h77,1, 1,8'h88,1, 1,  0,1, 1,8'h88,1,1));
    // Single-channel streaming on d1
    vecs.push_back(mk(0,8'h00,0, 1,8'h91,1, 1,  0,1, 1,8'h91,1,1));
    vecs.push_back(mk(0,8'h00,0, 1,8'h92,1, 1,  0,1, 1,8'h92,1,1));
    vecs.push_back(mk(0,8'h00,0, 1,8'h93,1, 1,  0,1, 1,8'h93,1,1));
    vecs.push_back(mk(0,8'h00,0, 1,8'h94,1, 1,  0,1, 1,8'h94,1,1));
    // Set pointer to 0, then open a d1 packet (LOCK1)
    vecs.push_back(mk(1,8'hD0,1, 0,8'h00,0, 1,  1,0, 1,8'hD0,1,0));
    vecs.push_back(mk(0,8'h00,0, 1,8'hC1,0, 1,  0,1, 1,8'hC1,0,1));

    d0 = '0; d1 = '0; d0_valid = 0; d1_valid = 0; d0_last = 0; d1_last = 0;
    y_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_y_valid", 0, {31'd0, y_valid}, 32'd0);
    check("rst_y", 0, {24'd0, y}, 32'd0);
    check("rst_s", 0, {31'd0, s}, 32'd0);
    check("rst_y_last", 0, {31'd0, y_last}, 32'd0);
    d0_valid = 1; d1_valid = 1; y_ready = 1;
    @(posedge clk); #1;
    check("rst_ready", 0, {30'd0, d0_ready, d1_ready}, 32'd0);
    check("rst_hold_valid", 0, {31'd0, y_valid}, 32'd0);
    d0_valid = 0; d1_valid = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset between edges while in LOCK1
    drive(mk(0,8'h00,0, 1,8'hC2,0, 1,  0,0, 0,8'h00,0,0));
    #2 rst_n = 1'b0;
    #1;
    check("arst_y_valid", 100, {31'd0, y_valid}, 32'd0);
    check("arst_s", 100, {31'd0, s}, 32'd0);
    check("arst_y", 100, {24'd0, y}, 32'd0);
    check("arst_ready", 100, {30'd0, d0_ready, d1_ready}, 32'd0);
    d1_valid = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // Lock and pointer both cleared: tie goes to d0
    apply(mk(1,8'hA0,1, 1,8'hB0,1, 1,  1,0, 1,8'hA0,1,0), 101);
    apply(mk(1,8'hA0,1, 1,8'hB0,1, 1,  0,1, 1,8'hB0,1,1), 102);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
